alu_exec: RTL and testbench

Sequential ALU execution unit that consumes the 3-bit operation select produced by the front-panel button controller and performs the selected operation on two unsigned operands. ADD/SUB/AND/XOR complete in one cycle. MUL (shift-add) and DIV (restoring) are iterative and take WIDTH cycles. A start/busy/done handshake lets the display/top-level logic launch an operation and capture a registered result.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_exec_if.sv | 35 +++
 rtl/alu_iter_unit.sv | 88 ++++++++
 rtl/alu_exec.sv | 130 +++++++++++++
 tb/tb_alu_exec.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode encoding, FSM state type and default operand
//                width for the ALU execution unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned SEL_W         = 3;

  // Opcodes share the encoding of the front-panel button controller's sel
  localparam logic [SEL_W-1:0] OP_ADD = 3'b000;
  localparam logic [SEL_W-1:0] OP_SUB = 3'b001;
  localparam logic [SEL_W-1:0] OP_AND = 3'b010;
  localparam logic [SEL_W-1:0] OP_XOR = 3'b011;
  localparam logic [SEL_W-1:0] OP_MUL = 3'b100;
  localparam logic [SEL_W-1:0] OP_DIV = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_exec_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_if
//  Description : Start/busy/done handshake and operand/result bus between the
//                issuing logic (master) and the ALU execution unit (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_exec_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic                 start;
  logic [SEL_W-1:0]     sel;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 div_by_zero;
  logic                 op_err;

  modport master (
    output start, sel, a, b,
    input  busy, done, result, div_by_zero, op_err
  );

  modport slave (
    input  start, sel, a, b,
    output busy, done, result, div_by_zero, op_err
  );

endinterface
`default_nettype wire

// File: rtl/alu_iter_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_iter_unit
//  Description : Iterative datapath shared by the shift-add multiplier and the
//                restoring divider. One iteration per clock for WIDTH clocks
//                after a load; o_next exposes the value the registers take on
//                the next step so the caller can capture the final result on
//                the same edge as the last iteration.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  input  wire logic               i_load,
  input  wire logic               i_is_div,
  input  wire logic [WIDTH-1:0]   i_a,
  input  wire logic [WIDTH-1:0]   i_b,
  output logic                    o_last,
  output logic [2*WIDTH-1:0]      o_next
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  // r_hi: running product high half / partial remainder
  // r_lo: multiplier being consumed LSB-first / dividend shifting into quotient
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_rem;
  logic             w_qbit;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic             w_unused_rem_msb;

  // One multiply or divide iteration computed from the current registers
  always_comb begin
    w_mul_sum = '0;
    w_shift   = {r_hi, r_lo[WIDTH-1]};
    w_qbit    = (w_shift >= {1'b0, r_b});
    w_rem     = w_shift - (w_qbit ? {1'b0, r_b} : '0);
    w_hi_nxt  = r_hi;
    w_lo_nxt  = r_lo;
    if (r_is_div) begin
      // Remainder is always below the divisor, so it fits in WIDTH bits
      w_hi_nxt = w_rem[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_qbit};
    end else begin
      w_mul_sum            = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
      {w_hi_nxt, w_lo_nxt} = {w_mul_sum, r_lo[WIDTH-1:1]};
    end
  end

  assign w_unused_rem_msb = w_rem[WIDTH];
  assign o_last           = (r_cnt == CW'(1));
  assign o_next           = {w_hi_nxt, w_lo_nxt};

  // Load operands, then step until the iteration counter runs out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (i_load) begin
      r_cnt    <= CW'(WIDTH);
      r_is_div <= i_is_div;
      r_b      <= i_b;
      r_hi     <= '0;
      r_lo     <= i_a;
    end else if (r_cnt != '0) begin
      r_cnt    <= r_cnt - CW'(1);
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec
//  Description : Sequential ALU execution unit. ADD/SUB/AND/XOR, illegal
//                opcodes and divide-by-zero finish one cycle after start;
//                MUL and DIV run WIDTH iterations in alu_iter_unit. Result
//                and flags are registered and held until the next operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  wire logic   clk,
  input  wire logic   reset_n,
  alu_exec_if.slave   bus
);

  state_t             r_state;
  logic               r_done;
  logic [2*WIDTH-1:0] r_result;
  logic               r_dbz;
  logic               r_operr;

  state_t             w_state_nxt;
  logic               w_done_nxt;
  logic [2*WIDTH-1:0] w_result_nxt;
  logic               w_dbz_nxt;
  logic               w_operr_nxt;
  logic               w_load;
  logic               w_last;
  logic [2*WIDTH-1:0] w_iter_next;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;

  assign w_add = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_sub = {1'b0, bus.a} - {1'b0, bus.b};

  alu_iter_unit #(
    .WIDTH    (WIDTH)
  ) u_iter (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_load),
    .i_is_div (bus.sel == OP_DIV),
    .i_a      (bus.a),
    .i_b      (bus.b),
    .o_last   (w_last),
    .o_next   (w_iter_next)
  );

  // Next-state, result and flag selection; start is only looked at in IDLE
  always_comb begin
    w_state_nxt  = r_state;
    w_done_nxt   = 1'b0;
    w_result_nxt = r_result;
    w_dbz_nxt    = r_dbz;
    w_operr_nxt  = r_operr;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_dbz_nxt   = 1'b0;
          w_operr_nxt = 1'b0;
          w_done_nxt  = 1'b1;
          case (bus.sel)
            OP_ADD: w_result_nxt = {{(WIDTH-1){1'b0}}, w_add};
            OP_SUB: w_result_nxt = {{(WIDTH-1){w_sub[WIDTH]}}, w_sub};
            OP_AND: w_result_nxt = {{WIDTH{1'b0}}, bus.a & bus.b};
            OP_XOR: w_result_nxt = {{WIDTH{1'b0}}, bus.a ^ bus.b};
            OP_MUL: begin
              w_done_nxt  = 1'b0;
              w_load      = 1'b1;
              w_state_nxt = ST_RUN;
            end
            OP_DIV: begin
              if (bus.b == '0) begin
                // Quotient saturates to all ones, dividend kept as remainder
                w_result_nxt = {bus.a, {WIDTH{1'b1}}};
                w_dbz_nxt    = 1'b1;
              end else begin
                w_done_nxt  = 1'b0;
                w_load      = 1'b1;
                w_state_nxt = ST_RUN;
              end
            end
            default: begin
              w_result_nxt = '0;
              w_operr_nxt  = 1'b1;
            end
          endcase
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_result_nxt = w_iter_next;
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, result and flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_done   <= 1'b0;
      r_result <= '0;
      r_dbz    <= 1'b0;
      r_operr  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
      r_dbz    <= w_dbz_nxt;
      r_operr  <= w_operr_nxt;
    end
  end

  assign bus.busy        = (r_state == ST_RUN);
  assign bus.done        = r_done;
  assign bus.result      = r_result;
  assign bus.div_by_zero = r_dbz;
  assign bus.op_err      = r_operr;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec
//  Description : Self-checking bench for alu_exec. Expected results are queued
//                when an operation is issued and compared when done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec;
  import alu_pkg::*;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [2*W-1:0] res;
    logic           dbz;
    logic           operr;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  alu_exec_if #(.WIDTH(W)) bus ();

  alu_exec #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  exp_t mon_exp;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Scoreboard: every done pulse must match the oldest issued operation
  always @(negedge clk) begin
    if (reset_n && bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: done=1 with nothing pending, result=%h", bus.result);
      end else begin
        mon_exp = sb_q.pop_front();
        n_checks++;
        if (bus.result !== mon_exp.res) begin
          n_fail++;
          $display("FAIL sb_result: got %h expected %h", bus.result, mon_exp.res);
        end
        n_checks++;
        if (bus.div_by_zero !== mon_exp.dbz) begin
          n_fail++;
          $display("FAIL sb_div_by_zero: got %b expected %b", bus.div_by_zero, mon_exp.dbz);
        end
        n_checks++;
        if (bus.op_err !== mon_exp.operr) begin
          n_fail++;
          $display("FAIL sb_op_err: got %b expected %b", bus.op_err, mon_exp.operr);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic exp_t mk(input logic [2*W-1:0] r, input logic d, input logic e);
    exp_t x;
    x.res = r; x.dbz = d; x.operr = e;
    return x;
  endfunction

  // Present an operation for one active edge; optionally queue its expectation
  task automatic drive_start(input logic [2:0] s, input logic [W-1:0] x,
                             input logic [W-1:0] y, input bit push, input exp_t e);
    @(negedge clk);
    bus.sel = s; bus.a = x; bus.b = y; bus.start = 1'b1;
    if (push) sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Called just after the accepting edge; reports edge offset of done and busy cycles
  task automatic wait_done(output int off, output int busy_cyc);
    off = -1; busy_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) begin
        off = i;
        break;
      end
      if (bus.busy === 1'b1) busy_cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.result !== '0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", bus.result); end
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", bus.div_by_zero); end
    n_checks++; if (bus.op_err !== 1'b0) begin n_fail++; $display("FAIL reset_op_err: got %b expected 0", bus.op_err); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_mul();
    int off, bc;
    drive_start(OP_MUL, 8'd200, 8'd3, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midmul_busy: got %b expected 1", bus.busy); end
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.result !== '0) begin n_fail++; $display("FAIL midrst_result: got %h expected 0", bus.result); end
    @(negedge clk);
    reset_n = 1'b1;
    drive_start(OP_ADD, 8'd5, 8'd7, 1'b1, mk(16'd12, 1'b0, 1'b0));
    wait_done(off, bc);
    n_checks++; if (off !== 0) begin n_fail++; $display("FAIL postrst_add_latency: got %0d expected 0", off); end
  endtask

  task automatic test_single_cycle();
    logic [2:0]   s_tab [4] = '{OP_ADD, OP_SUB, OP_AND, OP_XOR};
    logic [W-1:0] a_tab [4] = '{8'd255, 8'd3, 8'hF0, 8'hF0};
    logic [W-1:0] b_tab [4] = '{8'd1, 8'd5, 8'h3C, 8'h3C};
    logic [15:0]  r_tab [4] = '{16'h0100, 16'hFFFE, 16'h0030, 16'h00CC};
    int off, bc;
    for (int k = 0; k < 4; k++) begin
      drive_start(s_tab[k], a_tab[k], b_tab[k], 1'b1, mk(r_tab[k], 1'b0, 1'b0));
      wait_done(off, bc);
      n_checks++; if (off !== 0) begin n_fail++; $display("FAIL single_latency[%0d]: got %0d expected 0", k, off); end
      n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL single_busy[%0d]: got %0d busy cycles expected 0", k, bc); end
    end
  endtask

  task automatic test_mul();
    int off, bc;
    drive_start(OP_MUL, 8'd200, 8'd3, 1'b1, mk(16'h0258, 1'b0, 1'b0));
    wait_done(off, bc);
    n_checks++; if (off !== W) begin n_fail++; $display("FAIL mul_latency: got %0d expected %0d", off, W); end
    n_checks++; if (bc !== W) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d expected %0d", bc, W); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_at_done: got %b expected 0", bus.busy); end
    drive_start(OP_MUL, 8'd255, 8'd255, 1'b1, mk(16'hFE01, 1'b0, 1'b0));
    wait_done(off, bc);
    n_checks++; if (off !== W) begin n_fail++; $display("FAIL mul2_latency: got %0d expected %0d", off, W); end
  endtask

  task automatic test_div();
    int off, bc;
    drive_start(OP_DIV, 8'd200, 8'd7, 1'b1, mk(16'h041C, 1'b0, 1'b0));
    wait_done(off, bc);
    n_checks++; if (off !== W) begin n_fail++; $display("FAIL div_latency: got %0d expected %0d", off, W); end
    drive_start(OP_DIV, 8'd9, 8'd0, 1'b1, mk(16'h09FF, 1'b1, 1'b0));
    wait_done(off, bc);
    n_checks++; if (off !== 0) begin n_fail++; $display("FAIL div0_latency: got %0d expected 0", off); end
    n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL div0_busy: got %0d busy cycles expected 0", bc); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL div0_flag_held: got %b expected 1", bus.div_by_zero); end
    drive_start(OP_ADD, 8'd1, 8'd1, 1'b1, mk(16'd2, 1'b0, 1'b0));
    wait_done(off, bc);
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL div0_flag_clear: got %b expected 0", bus.div_by_zero); end
  endtask

  task automatic test_illegal();
    int off, bc;
    drive_start(3'b110, 8'd1, 8'd2, 1'b1, mk(16'h0000, 1'b0, 1'b1));
    wait_done(off, bc);
    n_checks++; if (off !== 0) begin n_fail++; $display("FAIL illegal_latency: got %0d expected 0", off); end
    drive_start(3'b111, 8'd9, 8'd9, 1'b1, mk(16'h0000, 1'b0, 1'b1));
    wait_done(off, bc);
    drive_start(OP_XOR, 8'h0F, 8'hFF, 1'b1, mk(16'h00F0, 1'b0, 1'b0));
    wait_done(off, bc);
  endtask

  task automatic test_busy_ignore();
    int off, bc;
    drive_start(OP_DIV, 8'd200, 8'd7, 1'b1, mk(16'h041C, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.sel = OP_ADD; bus.a = 8'd1; bus.b = 8'd1; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    wait_done(off, bc);
    n_checks++; if (off !== W - 3) begin n_fail++; $display("FAIL ignore_latency: got %0d expected %0d", off, W - 3); end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL ignore_extra_done[%0d]: got %b expected 0", k, bus.done); end
    end
  endtask

  task automatic test_random_iter();
    logic [W-1:0] ra, rb;
    logic [15:0]  ex;
    int off, bc;
    for (int k = 0; k < 6; k++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(1, 255));
      if (k[0]) begin
        ex = {8'(ra % rb), 8'(ra / rb)};
        drive_start(OP_DIV, ra, rb, 1'b1, mk(ex, 1'b0, 1'b0));
      end else begin
        ex = 16'(ra) * 16'(rb);
        drive_start(OP_MUL, ra, rb, 1'b1, mk(ex, 1'b0, 1'b0));
      end
      wait_done(off, bc);
      n_checks++; if (off !== W) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", k, off, W); end
    end
  endtask

  task automatic test_back_to_back();
    int off, bc;
    @(negedge clk);
    bus.sel = OP_MUL; bus.a = 8'd200; bus.b = 8'd3; bus.start = 1'b1;
    sb_q.push_back(mk(16'h0258, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    bus.sel = OP_ADD; bus.a = 8'd5; bus.b = 8'd7;
    sb_q.push_back(mk(16'd12, 1'b0, 1'b0));
    wait_done(off, bc);
    n_checks++; if (off !== W) begin n_fail++; $display("FAIL b2b_mul_latency: got %0d expected %0d", off, W); end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_add_done: got %b expected 1", bus.done); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_add_busy: got %b expected 0", bus.busy); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_pulse: got %b expected 0", bus.done); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.sel   = '0;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_reset_mid_mul();
    test_single_cycle();
    test_mul();
    test_div();
    test_illegal();
    test_busy_ignore();
    test_random_iter();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d operations never completed, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
